// File: rtl/dmem_responder_pkg.sv
// Shared constants for dmem_responder: data width, MMIO register offsets,
// TX_STATUS bit positions and the default MMIO window base.
package dmem_responder_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    // MMIO register offsets (addr[7:0])
    localparam logic [7:0] OFF_CYCLE_LO  = 8'h00;
    localparam logic [7:0] OFF_CYCLE_HI  = 8'h04;
    localparam logic [7:0] OFF_TX_DATA   = 8'h10;
    localparam logic [7:0] OFF_TX_STATUS = 8'h14;

    // TX_STATUS field positions
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

endpackage

// File: rtl/dmem_responder_tx_fifo_sync.sv
// tx_fifo_sync: single-clock circular FIFO with count. A push while full is
// accepted only when a pop happens in the same cycle; the storage array is
// cleared on reset so the head reads a defined value when empty.
module tx_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Pointer, count and storage update; pointers wrap as DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data RAM plus MMIO window (64-bit cycle counter, console
// TX FIFO) on the core's M-stage memory port. Reads are combinational.
// Optional macro DMEM_MISALIGN_CHK_EN adds a sticky misalign output.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            we,
    input  logic [3:0]      amp,
    output logic [XLEN-1:0] rdata,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    output logic            misalign
`endif
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] r_mem [DEPTH_WORDS];
    logic [63:0]     r_cycle;
    logic            r_ovf;

    logic            w_is_mmio;
    logic [7:0]      w_off;
    logic [AW-1:0]   w_idx;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [XLEN-1:0] w_status;

    // Upper address bits alias into the RAM and are deliberately dropped
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, addr[XLEN-1:AW+2]};

    assign w_is_mmio = (addr[31:8] == MMIO_BASE[31:8]);
    assign w_off     = addr[7:0];
    assign w_idx     = addr[AW+1:2];

    assign w_push    = we & w_is_mmio & (w_off == OFF_TX_DATA) & amp[0];
    assign w_pop     = tx_valid & tx_ready;
    assign tx_valid  = ~w_empty;

    tx_fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txq (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (wdata[7:0]),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (tx_data)
    );

    // Byte-lane RAM write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (we && !w_is_mmio) begin
            for (int i = 0; i < 4; i++)
                if (amp[i]) r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // Free-running 64-bit cycle counter
    always_ff @(posedge clk) begin
        if (reset) r_cycle <= '0;
        else       r_cycle <= r_cycle + 64'd1;
    end

    // Sticky overflow: set by a push dropped on a full FIFO with no pop, W1C via TX_STATUS
    always_ff @(posedge clk) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (w_push && w_full && !w_pop)
            r_ovf <= 1'b1;
        else if (we && w_is_mmio && (w_off == OFF_TX_STATUS) && amp[0] && wdata[ST_OVF])
            r_ovf <= 1'b0;
    end

    // TX_STATUS word assembly
    always_comb begin
        w_status                   = '0;
        w_status[ST_EMPTY]         = w_empty;
        w_status[ST_FULL]          = w_full;
        w_status[ST_OVF]           = r_ovf;
        w_status[ST_CNT_LSB +: 8]  = 8'(w_count);
    end

    // Read mux: RAM word or MMIO register, undefined offsets read zero
    always_comb begin
        rdata = '0;
        if (w_is_mmio) begin
            case (w_off)
                OFF_CYCLE_LO:  rdata = r_cycle[31:0];
                OFF_CYCLE_HI:  rdata = r_cycle[63:32];
                OFF_TX_STATUS: rdata = w_status;
                default:       rdata = '0;
            endcase
        end else begin
            rdata = r_mem[w_idx];
        end
    end

`ifdef DMEM_MISALIGN_CHK_EN
    // No read strobe exists, so any cycle addressing the MMIO window counts as an access
    logic w_bad_amp;
    assign w_bad_amp = !(amp inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                     4'b0011, 4'b1100, 4'b1111});

    // Sticky misalignment flag
    always_ff @(posedge clk) begin
        if (reset)
            misalign <= 1'b0;
        else if ((we && w_bad_amp) || (w_is_mmio && addr[1:0] != 2'b00))
            misalign <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lane writes via a vector table,
// then hand sequences for the cycle counter, TX FIFO and reset flush.
module tb_dmem_responder;
    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        we;
    logic [3:0]  amp;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
`ifdef DMEM_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    dmem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .amp      (amp),
        .rdata    (rdata),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
`ifdef DMEM_MISALIGN_CHK_EN
        ,
        .misalign (misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] wd;
        logic        w;
        logic [3:0]  m;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic w, input logic [3:0] m);
        addr = a; wdata = wd; we = w; amp = m;
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        drive(MB + 32'h10, {24'h0, b}, 1'b1, 4'h1);
        @(posedge clk);
    endtask

    task automatic idle_at(input logic [31:0] a);
        @(negedge clk);
        drive(a, 32'h0, 1'b0, 4'h0);
        #1;
    endtask

    task automatic drain(input logic [7:0] first, input int n, input logic [7:0] last_extra, input logic use_extra);
        for (int i = 0; i < n; i++) begin
            logic [7:0] e;
            e = (use_extra && i == n-1) ? last_extra : first + 8'(i);
            @(negedge clk);
            drive(32'h0, 32'h0, 1'b0, 4'h0);
            tx_ready = 1'b1;
            #1;
            chk("drain_valid", {31'h0, tx_valid}, 32'h1);
            chk("drain_data", {24'h0, tx_data}, {24'h0, e});
            @(posedge clk);
        end
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    initial begin
        vt[0]  = '{"wr_full",    32'h40,      32'h1122_3344, 1'b1, 4'hF, 1'b0, 32'h0};
        vt[1]  = '{"rd_full",    32'h40,      32'h0,         1'b0, 4'h0, 1'b1, 32'h1122_3344};
        vt[2]  = '{"sh_upper",   32'h40,      32'hAAAA_0000, 1'b1, 4'hC, 1'b1, 32'h1122_3344};
        vt[3]  = '{"rd_merge",   32'h40,      32'h0,         1'b0, 4'h0, 1'b1, 32'hAAAA_3344};
        vt[4]  = '{"amp0_wr",    32'h40,      32'hFFFF_FFFF, 1'b1, 4'h0, 1'b1, 32'hAAAA_3344};
        vt[5]  = '{"amp0_keep",  32'h40,      32'h0,         1'b0, 4'h0, 1'b1, 32'hAAAA_3344};
        vt[6]  = '{"alias",      32'h1040,    32'h0,         1'b0, 4'h0, 1'b1, 32'hAAAA_3344};
        vt[7]  = '{"wr_zero44",  32'h44,      32'h0,         1'b1, 4'hF, 1'b0, 32'h0};
        vt[8]  = '{"sb_lane1",   32'h44,      32'h1234_BB78, 1'b1, 4'h2, 1'b1, 32'h0};
        vt[9]  = '{"rd_lane1",   32'h44,      32'h0,         1'b0, 4'h0, 1'b1, 32'h0000_BB00};
        vt[10] = '{"mmio_undef", MB + 32'h08, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b1, 32'h0};
        vt[11] = '{"txdata_rd",  MB + 32'h10, 32'h0,         1'b0, 4'h0, 1'b1, 32'h0};

        reset = 1'b1; tx_ready = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state, then counter after five released edges
        drive(MB + 32'h14, 32'h0, 1'b0, 4'h0); #1;
        chk("rst_status", rdata, 32'h0000_0001);
        chk("rst_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_txdata", {24'h0, tx_data}, 32'h0);
        repeat (5) @(posedge clk);
        idle_at(MB + 32'h00);
        chk("cycle_lo_5", rdata, 32'h5);

        // Counter carry into the high word
        force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
        #1;
        chk("cycle_pre", rdata, 32'hFFFF_FFFF);
        release dut.r_cycle;
        @(posedge clk);
        idle_at(MB + 32'h04);
        chk("cycle_hi_wrap", rdata, 32'h1);
        addr = MB + 32'h00; #1;
        chk("cycle_lo_wrap", rdata, 32'h0);

        // RAM / MMIO decode vectors: rdata checked before each vector's edge
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vt[i].a, vt[i].wd, vt[i].w, vt[i].m);
            #1;
            if (vt[i].chk) chk(vt[i].name, rdata, vt[i].exp);
            @(posedge clk);
        end

        // Fill past capacity with consumer stalled
        for (int i = 0; i < 9; i++) push(8'h41 + 8'(i));
        idle_at(MB + 32'h14);
        chk("status_ovf", rdata, 32'h0000_0806);
        chk("head_41", {24'h0, tx_data}, 32'h41);
        drain(8'h41, 8, 8'h0, 1'b0);
        idle_at(MB + 32'h14);
        chk("status_empty", rdata, 32'h0000_0005);

        // Clear overflow, refill, then push while popping on a full FIFO
        @(negedge clk);
        drive(MB + 32'h14, 32'h4, 1'b1, 4'h1);
        @(posedge clk);
        idle_at(MB + 32'h14);
        chk("ovf_clear", rdata, 32'h0000_0001);
        for (int i = 0; i < 8; i++) push(8'h41 + 8'(i));
        @(negedge clk);
        drive(MB + 32'h10, 32'h5A, 1'b1, 4'h1);
        tx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_ready = 1'b0;
        drive(MB + 32'h14, 32'h0, 1'b0, 4'h0); #1;
        chk("full_pushpop", rdata, 32'h0000_0802);
        chk("head_42", {24'h0, tx_data}, 32'h42);
        drain(8'h42, 8, 8'h5A, 1'b1);

        // Reset with bytes pending flushes the FIFO but keeps RAM
        for (int i = 0; i < 3; i++) push(8'h61 + 8'(i));
        idle_at(MB + 32'h14);
        chk("three_pending", rdata, 32'h0000_0300);
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        addr = MB + 32'h14; #1;
        chk("flush_status", rdata, 32'h0000_0001);
        chk("flush_valid", {31'h0, tx_valid}, 32'h0);
        addr = 32'h40; #1;
        chk("ram_kept", rdata, 32'hAAAA_3344);

`ifdef DMEM_MISALIGN_CHK_EN
        chk("mis_rst", {31'h0, misalign}, 32'h0);
        @(negedge clk);
        drive(32'h48, 32'h0, 1'b1, 4'b0110);
        @(posedge clk);
        idle_at(32'h48);
        chk("mis_set", {31'h0, misalign}, 32'h1);
        repeat (3) @(posedge clk);
        idle_at(32'h48);
        chk("mis_sticky", {31'h0, misalign}, 32'h1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        chk("mis_clear", {31'h0, misalign}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
